la_capture_engine: RTL

Parametrised trigger-and-buffer capture engine for the logic analyzer. It continuously records NCH channels into a circular sample RAM and fires on a masked value or edge match. It keeps a configurable number of pre-trigger samples, then freezes the buffer for in-order readout. It replaces the fixed 4-channel raw/trigger capture paths and sits between the channel inputs and the top-level output mux.

---
 rtl/la_pkg.sv | 33 +++
 rtl/la_sample_ram.sv | 37 +++
 rtl/la_capture_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path: state and trigger-mode
// encodings plus the masked pattern-match helper.
package la_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_PRE   = ST_PRE,
    S_ARMED = ST_ARMED,
    S_POST  = ST_POST,
    S_DONE  = ST_DONE
  } la_state_e;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } la_trig_mode_e;

  localparam int MAX_NCH = 8;

  // Unused channels are zero-extended on both data and mask, so they never block a match.
  function automatic logic la_match(input logic [MAX_NCH-1:0] data,
                                    input logic [MAX_NCH-1:0] mask,
                                    input logic [MAX_NCH-1:0] value);
    return (((data ^ value) & mask) == {MAX_NCH{1'b0}});
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Circular sample storage: one write port, one registered read port.
module la_sample_ram
  import la_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [NCH-1:0] wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output logic [NCH-1:0] rdata
);

  logic [NCH-1:0] mem_r [DEPTH];

  // Sample array write; contents need no reset since only written entries are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {NCH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/la_capture_engine.sv
// Trigger-and-buffer capture engine: records NCH channels into a circular RAM,
// fires on a masked level/edge match, keeps pre-trigger history, then reads out in order.
module la_capture_engine
  import la_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arm,
  input  logic [NCH-1:0] in_data,
  input  logic [NCH-1:0] cfg_mask,
  input  logic [NCH-1:0] cfg_value,
  input  logic           cfg_edge,
  input  logic [AW-1:0]  cfg_pretrig,
  input  logic           rd_en,
  output logic [NCH-1:0] rd_data,
  output logic           rd_valid,
  output logic [2:0]     state,
  output logic           triggered,
  output logic           done
);

  la_state_e     state_r, state_nx;
  logic          arm_d_r, match_d_r, triggered_r, done_r, rd_valid_r;
  logic [AW-1:0] wptr_r, wptr_nx, cnt_r, cnt_nx, post_r, post_nx;
  logic [AW-1:0] rptr_r, rptr_nx, rcnt_r, rcnt_nx;
  logic [AW-1:0] post_load_s;
  logic          match_s, trig_s, we_s, re_s, trig_set_s;

  assign match_s     = la_match(MAX_NCH'(in_data), MAX_NCH'(cfg_mask), MAX_NCH'(cfg_value));
  assign trig_s      = (la_trig_mode_e'(cfg_edge) == TRIG_EDGE) ? (match_s & ~match_d_r) : match_s;
  assign post_load_s = AW'(DEPTH - 1) - cfg_pretrig;

  // Next-state, pointer and RAM-strobe logic; a low arm outranks every other event.
  always_comb begin
    state_nx   = state_r;
    wptr_nx    = wptr_r;
    cnt_nx     = cnt_r;
    post_nx    = post_r;
    rptr_nx    = rptr_r;
    rcnt_nx    = rcnt_r;
    we_s       = 1'b0;
    re_s       = 1'b0;
    trig_set_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (arm && !arm_d_r) begin
          state_nx = S_PRE;
          wptr_nx  = {AW{1'b0}};
          cnt_nx   = {AW{1'b0}};
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_PRE: begin
        if (!arm) begin
          state_nx = S_IDLE;
        end else if (cnt_r == cfg_pretrig) begin
          state_nx = S_ARMED;
        end else begin
          we_s    = 1'b1;
          wptr_nx = wptr_r + AW'(1);
          cnt_nx  = cnt_r + AW'(1);
          if ((cnt_r + AW'(1)) == cfg_pretrig) begin
            state_nx = S_ARMED;
          end else begin
            state_nx = S_PRE;
          end
        end
      end
      S_ARMED: begin
        if (!arm) begin
          state_nx = S_IDLE;
        end else begin
          we_s    = 1'b1;
          wptr_nx = wptr_r + AW'(1);
          if (trig_s) begin
            trig_set_s = 1'b1;
            post_nx    = post_load_s;
            if (post_load_s == {AW{1'b0}}) begin
              state_nx = S_DONE;
              rptr_nx  = wptr_nx;
              rcnt_nx  = {AW{1'b0}};
            end else begin
              state_nx = S_POST;
            end
          end else begin
            state_nx = S_ARMED;
          end
        end
      end
      S_POST: begin
        if (!arm) begin
          state_nx = S_IDLE;
        end else begin
          we_s    = 1'b1;
          wptr_nx = wptr_r + AW'(1);
          post_nx = post_r - AW'(1);
          if (post_r == AW'(1)) begin
            state_nx = S_DONE;
            rptr_nx  = wptr_nx;
            rcnt_nx  = {AW{1'b0}};
          end else begin
            state_nx = S_POST;
          end
        end
      end
      S_DONE: begin
        if (!arm) begin
          state_nx = S_IDLE;
        end else if (rd_en) begin
          re_s    = 1'b1;
          rptr_nx = rptr_r + AW'(1);
          rcnt_nx = rcnt_r + AW'(1);
          if (rcnt_r == AW'(DEPTH - 1)) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          state_nx = S_DONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      wptr_r      <= {AW{1'b0}};
      cnt_r       <= {AW{1'b0}};
      post_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      rcnt_r      <= {AW{1'b0}};
      arm_d_r     <= 1'b0;
      match_d_r   <= 1'b0;
      triggered_r <= 1'b0;
      done_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nx;
      wptr_r      <= wptr_nx;
      cnt_r       <= cnt_nx;
      post_r      <= post_nx;
      rptr_r      <= rptr_nx;
      rcnt_r      <= rcnt_nx;
      arm_d_r     <= arm;
      match_d_r   <= (state_r == S_ARMED) ? match_s : 1'b1;
      triggered_r <= (state_nx == S_IDLE) ? 1'b0 : (trig_set_s | triggered_r);
      done_r      <= (state_nx == S_DONE);
      rd_valid_r  <= re_s;
    end
  end

  la_sample_ram #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (wptr_r),
    .wdata (in_data),
    .re    (re_s),
    .raddr (rptr_r),
    .rdata (rd_data)
  );

  assign state     = state_r;
  assign triggered = triggered_r;
  assign done      = done_r;
  assign rd_valid  = rd_valid_r;

endmodule
